// File: rtl/seg_pkg.sv
// Shared constants and sample type for the 7-segment scan receive path.
// Segment vectors are ordered bit6 = a ... bit0 = g, 1 = lit.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam logic [3:0] BCD_BAD   = 4'hE;

   // Upper bound on scanned digits; narrower buses are zero-extended into the sample.
   localparam int MAX_DIGITS = 16;

   typedef struct packed {
      logic [6:0]            seg;
      logic [MAX_DIGITS-1:0] dig_sel;
   } seg_scan_sample;

endpackage

// File: rtl/seg_pattern_decoder.sv
// Inverse 7-segment table: segment pattern -> {BCD nibble, dark flag, illegal flag}.
// Latency: combinational. Backpressure: none.
// A dark digit is legal and reported as BCD_BLANK; any non-digit pattern yields BCD_BAD.
module seg_pattern_decoder
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       bad
);

   always_comb begin
      nibble = BCD_BAD;
      blank  = 1'b0;
      bad    = 1'b0;
      case (seg)
         SEG_0:     nibble = 4'd0;
         SEG_1:     nibble = 4'd1;
         SEG_2:     nibble = 4'd2;
         SEG_3:     nibble = 4'd3;
         SEG_4:     nibble = 4'd4;
         SEG_5:     nibble = 4'd5;
         SEG_6:     nibble = 4'd6;
         SEG_7:     nibble = 4'd7;
         SEG_8:     nibble = 4'd8;
         SEG_9:     nibble = 4'd9;
         SEG_BLANK: begin
            nibble = BCD_BLANK;
            blank  = 1'b1;
         end
         default:   bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_reader.sv
// Samples a multiplexed 7-segment bus, debounces each digit dwell and publishes BCD frames.
// Latency: capture STABLE_CYCLES edges after a dwell starts; frame commit one edge after the last capture.
// Backpressure: none; the monitored bus cannot be stalled, frames are held until the next commit.
module seg_scan_reader
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   blank_out,
   output logic                    frame_valid,
   output logic                    frame_err,
   output logic                    pattern_err
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   seg_scan_sample s_cur, s_prev, s_next;

   logic [CW-1:0]             cnt, cnt_next;
   logic                      dwell_done;
   logic                      same, capture, commit;
   logic [4*NUM_DIGITS-1:0]   shadow;
   logic [NUM_DIGITS-1:0]     captured, blank_m, bad_m;
   logic                      err_pend;
   logic [3:0]                dec_nibble;
   logic                      dec_blank, dec_bad;

   seg_pattern_decoder u_dec (
      .seg    (s_cur.seg),
      .nibble (dec_nibble),
      .blank  (dec_blank),
      .bad    (dec_bad)
   );

   always_comb begin
      s_next         = '0;
      s_next.seg     = seg_in;
      s_next.dig_sel[NUM_DIGITS-1:0] = dig_sel;

      same     = (s_cur == s_prev);
      cnt_next = CW'(1);
      if (same)
         cnt_next = (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);

      // One capture per dwell: the first edge at which the run length hits the threshold.
      capture = (cnt_next == CW'(STABLE_CYCLES)) && !dwell_done && $onehot(s_cur.dig_sel);
      commit  = &captured;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_cur       <= '0;
         s_prev      <= '0;
         cnt         <= '0;
         dwell_done  <= 1'b0;
         shadow      <= '0;
         captured    <= '0;
         blank_m     <= '0;
         bad_m       <= '0;
         err_pend    <= 1'b0;
         bcd_out     <= {NUM_DIGITS{BCD_BLANK}};
         blank_out   <= '1;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         pattern_err <= 1'b0;
      end else begin
         s_cur       <= s_next;
         s_prev      <= s_cur;
         cnt         <= cnt_next;
         err_pend    <= capture && dec_bad;
         pattern_err <= err_pend;
         frame_valid <= commit;

         if (!same)
            dwell_done <= 1'b0;
         else if (capture)
            dwell_done <= 1'b1;

         if (commit) begin
            bcd_out   <= shadow;
            blank_out <= blank_m;
            frame_err <= |bad_m;
         end

         // Clearing first lets a capture on the commit edge seed the next frame.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit) begin
               captured[i] <= 1'b0;
               bad_m[i]    <= 1'b0;
            end
            if (capture && s_cur.dig_sel[i]) begin
               shadow[4*i +: 4] <= dec_nibble;
               captured[i]      <= 1'b1;
               blank_m[i]       <= dec_blank;
               bad_m[i]         <= dec_bad;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed and random scans of seg_scan_reader against a dwell-level frame model,
// plus an exhaustive sweep of the pattern decoder.
module tb_seg_scan_reader;

   localparam int ND = 4;
   localparam int SC = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [6:0]      seg_in;
   logic [ND-1:0]   dig_sel;
   logic [4*ND-1:0] bcd_out;
   logic [ND-1:0]   blank_out;
   logic            frame_valid, frame_err, pattern_err;

   logic [6:0]      dcode;
   logic [3:0]      d_nib;
   logic            d_blank, d_bad;

   seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .dig_sel     (dig_sel),
      .bcd_out     (bcd_out),
      .blank_out   (blank_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .pattern_err (pattern_err)
   );

   seg_pattern_decoder u_dec_ut (
      .seg    (dcode),
      .nibble (d_nib),
      .blank  (d_blank),
      .bad    (d_bad)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int errors = 0;
   int checks = 0;

   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   // Observed frames
   logic [4*ND-1:0] got_bcd[$];
   logic [ND-1:0]   got_blank[$];
   logic            got_err[$];
   int              got_cyc[$];
   int              got_perr = 0;

   always @(negedge clk) begin
      if (frame_valid) begin
         got_bcd.push_back(bcd_out);
         got_blank.push_back(blank_out);
         got_err.push_back(frame_err);
         got_cyc.push_back(cyc);
      end
      if (pattern_err) got_perr++;
   end

   // Reference model: list of dwells (merged when identical) and per-digit frame state.
   typedef struct {
      logic [6:0]    seg;
      logic [ND-1:0] sel;
      int            len;
   } run_t;

   run_t            runs[$];
   logic [3:0]      m_nib[ND];
   bit              m_blank[ND];
   bit              m_bad[ND];
   bit              m_cap[ND];
   logic [4*ND-1:0] exp_bcd[$];
   logic [ND-1:0]   exp_blank[$];
   logic            exp_err[$];
   int              exp_perr = 0;

   function automatic logic [5:0] ref_dec(input logic [6:0] s);
      if (s == 7'd0) return {4'hF, 1'b1, 1'b0};
      for (int d = 0; d < 10; d++)
         if (pat[d] == s) return {4'(d), 2'b00};
      return {4'hE, 2'b01};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < ND; i++) begin
         m_cap[i] = 0;
         m_bad[i] = 0;
      end
      runs.delete();
   endtask

   task automatic model_eval();
      foreach (runs[k]) begin
         run_t r = runs[k];
         if (r.len >= SC && $onehot(r.sel)) begin
            int idx = 0;
            logic [5:0] dv = ref_dec(r.seg);
            bit all = 1;
            for (int i = 0; i < ND; i++) if (r.sel[i]) idx = i;
            m_nib[idx]   = dv[5:2];
            m_blank[idx] = dv[1];
            m_bad[idx]   = dv[0];
            m_cap[idx]   = 1;
            if (dv[0]) exp_perr++;
            for (int i = 0; i < ND; i++) all &= m_cap[i];
            if (all) begin
               logic [4*ND-1:0] b;
               logic [ND-1:0]   bl;
               bit              e = 0;
               for (int i = 0; i < ND; i++) begin
                  b[4*i +: 4] = m_nib[i];
                  bl[i]       = m_blank[i];
                  e          |= m_bad[i];
               end
               exp_bcd.push_back(b);
               exp_blank.push_back(bl);
               exp_err.push_back(e);
               for (int i = 0; i < ND; i++) begin
                  m_cap[i] = 0;
                  m_bad[i] = 0;
               end
            end
         end
      end
      runs.delete();
   endtask

   int last_start;

   task automatic dwell(input logic [6:0] s, input logic [ND-1:0] d, input int n);
      seg_in     = s;
      dig_sel    = d;
      last_start = cyc;
      if (runs.size() > 0 && runs[runs.size()-1].seg == s && runs[runs.size()-1].sel == d)
         runs[runs.size()-1].len = runs[runs.size()-1].len + n;
      else
         runs.push_back('{seg: s, sel: d, len: n});
      repeat (n) @(negedge clk);
   endtask

   task automatic check_frames(input string tag);
      int n;
      dwell(7'd0, '0, 6);
      model_eval();
      chk({tag, "_nframes"}, got_bcd.size(), exp_bcd.size());
      n = (got_bcd.size() < exp_bcd.size()) ? got_bcd.size() : exp_bcd.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_bcd"},   got_bcd[i],   exp_bcd[i]);
         chk({tag, "_blank"}, got_blank[i], exp_blank[i]);
         chk({tag, "_ferr"},  got_err[i],   exp_err[i]);
      end
      chk({tag, "_perr"}, got_perr, exp_perr);
      got_bcd.delete(); got_blank.delete(); got_err.delete(); got_cyc.delete();
      exp_bcd.delete(); exp_blank.delete(); exp_err.delete();
      got_perr = 0;
      exp_perr = 0;
   endtask

   task automatic do_reset(input string tag);
      model_eval();
      rst     = 1'b1;
      seg_in  = 7'd0;
      dig_sel = '0;
      repeat (2) @(negedge clk);
      chk({tag, "_bcd"},   bcd_out,     16'hFFFF);
      chk({tag, "_blank"}, blank_out,   4'b1111);
      chk({tag, "_fv"},    frame_valid, 1'b0);
      chk({tag, "_ferr"},  frame_err,   1'b0);
      chk({tag, "_perr"},  pattern_err, 1'b0);
      rst = 1'b0;
      model_clear();
      got_bcd.delete(); got_blank.delete(); got_err.delete(); got_cyc.delete();
      exp_bcd.delete(); exp_blank.delete(); exp_err.delete();
      got_perr = 0;
      exp_perr = 0;
   endtask

   initial begin
      int t3;
      logic [6:0] s;
      logic [ND-1:0] d;

      rst     = 1'b1;
      seg_in  = 7'd0;
      dig_sel = '0;
      dcode   = 7'd0;
      model_clear();
      @(negedge clk);
      do_reset("reset_init");

      // Decoder sweep over all 128 codes
      for (int c = 0; c < 128; c++) begin
         dcode = 7'(c);
         #1;
         chk("decoder", {d_nib, d_blank, d_bad}, ref_dec(7'(c)));
      end

      // Clean scan "2024"
      dwell(pat[2], 4'b0001, 8);
      dwell(pat[0], 4'b0010, 8);
      dwell(pat[2], 4'b0100, 8);
      t3 = cyc;
      dwell(pat[4], 4'b1000, 8);
      dwell(7'd0, '0, 6);
      chk("clean_count", got_bcd.size(), 1);
      if (got_bcd.size() > 0) begin
         chk("clean_bcd",     got_bcd[0], 16'h4202);
         chk("clean_ferr",    got_err[0], 1'b0);
         chk("clean_latency", got_cyc[0], t3 + SC + 2);
         chk("clean_hold",    bcd_out,    16'h4202);
      end
      check_frames("clean");

      // Reset mid-scan drops the partial frame
      dwell(pat[1], 4'b0001, 8);
      dwell(pat[3], 4'b0010, 8);
      dwell(pat[5], 4'b0100, 2);
      do_reset("reset_mid");
      dwell(pat[5], 4'b0100, 8);
      dwell(pat[6], 4'b1000, 8);
      check_frames("after_reset_partial");
      dwell(pat[7], 4'b0001, 8);
      dwell(pat[8], 4'b0010, 8);
      dwell(pat[9], 4'b0100, 8);
      dwell(pat[0], 4'b1000, 8);
      check_frames("after_reset_full");

      // Debounce: a 3-cycle dwell is ignored
      do_reset("reset_deb");
      dwell(pat[2], 4'b0001, 8);
      dwell(pat[0], 4'b0010, 3);
      dwell(pat[2], 4'b0100, 8);
      dwell(pat[4], 4'b1000, 8);
      check_frames("debounce_short");
      dwell(pat[0], 4'b0010, 8);
      check_frames("debounce_full");

      // Illegal pattern on digit 1
      dwell(pat[2], 4'b0001, 8);
      dwell(7'b1000000, 4'b0010, 8);
      dwell(pat[2], 4'b0100, 8);
      dwell(pat[4], 4'b1000, 8);
      check_frames("illegal");

      // Non-one-hot select and a dark digit
      dwell(pat[8], 4'b0011, 10);
      dwell(pat[1], 4'b0001, 8);
      dwell(pat[3], 4'b0010, 8);
      dwell(pat[6], 4'b0100, 8);
      dwell(7'd0,   4'b1000, 8);
      check_frames("blank_multihot");

      // Recapture: latest value wins
      dwell(pat[5], 4'b0001, 8);
      dwell(pat[7], 4'b0001, 8);
      dwell(pat[1], 4'b0010, 8);
      dwell(pat[2], 4'b0100, 8);
      dwell(pat[3], 4'b1000, 8);
      check_frames("recapture");

      // Random scans
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
               7:       s = 7'd0;
               8, 9:    s = 7'($urandom_range(0, 127));
               default: s = pat[$urandom_range(0, 9)];
            endcase
            case ($urandom_range(0, 9))
               8:       d = '0;
               9:       d = ND'($urandom_range(0, 15));
               default: d = ND'(1 << $urandom_range(0, ND-1));
            endcase
            dwell(s, d, $urandom_range(1, 8));
         end
         check_frames("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Reconstructs BCD digits by sampling a multiplexed 7-segment bus: segment lines plus one-hot digit select.
- It is the receiving end of the BCD-to-segment path: pattern back to BCD.
- Used as a self-check monitor on the display path and for loopback of the board's display outputs.
- Debounces each digit dwell, inverse-decodes the pattern, and publishes a complete frame once every digit has been seen.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; width of dig_sel.
- STABLE_CYCLES, 4: number of consecutive identical samples required to accept a dwell. Legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- seg_in  input  7  segment lines; bit 6 = a … bit 0 = g; 1 = lit.
- dig_sel  input  NUM_DIGITS  digit enable, one-hot, active-high; bit i = digit i.
- bcd_out  output  4*NUM_DIGITS  committed frame; nibble i = digit i.
- blank_out  output  NUM_DIGITS  bit i = 1 when digit i was dark (seg 0000000).
- frame_valid  output  1  one-cycle pulse on each frame commit.
- frame_err  output  1  held with the frame; 1 if any digit in the committed frame had an illegal pattern.
- pattern_err  output  1  one-cycle pulse when an illegal pattern is captured.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - bcd_out to all 4'hF
  - blank_out to all 1s
  - frame_valid, frame_err and pattern_err to 0
  - shadow slots, captured mask, bad mask, stability counter and dwell-done flag cleared
- Reset takes priority over every other event. A frame in progress when reset is asserted is discarded.
- Sampling: seg_in and dig_sel are registered every edge into sample register S. All logic uses S.
- Stability:
  - When S equals the previous S, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter is set to 1 and dwell_done is cleared.
- Capture:
  - Occurs when the counter reaches STABLE_CYCLES, dwell_done=0, and S.dig_sel is exactly one-hot.
  - On capture: write the decoded nibble to shadow[i], set captured[i], and set dwell_done. Exactly one capture per dwell.
  - If dig_sel is zero or multi-hot, no capture; the counter still runs but is ignored.
- Inverse decode (legal patterns 0–9):
  - 0: 1111110
  - 1: 0110000
  - 2: 1101101
  - 3: 1111001
  - 4: 0110011
  - 5: 1011011
  - 6: 1011111
  - 7: 1110000
  - 8: 1111111
  - 9: 1111011
  - 0000000 → nibble 4'hF with blank[i]=1. This is legal, not an error.
  - Any other pattern → nibble 4'hE, bad[i]=1, and pattern_err pulses on the edge after capture.
- Recapture: a digit recaptured before the frame completes overwrites shadow[i], blank[i] and bad[i]. Latest wins.
- Commit:
  - Triggered on the edge after captured becomes all ones.
  - bcd_out ← shadow, blank_out ← blank mask, frame_err ← OR of the bad mask.
  - frame_valid is high for exactly that cycle.
  - The captured and bad masks clear in the same edge.
  - A capture coinciding with the commit edge belongs to the next frame.
- Latency: with inputs changing just before edge k, samples are taken at k..k+STABLE_CYCLES-1.
  - Capture occurs at edge k+STABLE_CYCLES.
  - For the last digit, commit and frame_valid occur at edge k+STABLE_CYCLES+1.
- A glitch shorter than STABLE_CYCLES samples is never captured, and it restarts the dwell.

Decomposition:
- Package seg_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK (7-bit, bit6=a)
  - BCD_BLANK=4'hF and BCD_BAD=4'hE
  - the seg_scan_sample struct (seg, dig_sel)
- One sub-module: seg_pattern_decoder, a combinational 7-bit → {nibble, blank, bad} inverse table. It is separately unit-tested against every 128 codes.
- The top holds the sampler, stability counter, shadow, masks and commit logic.

Test Plan:
- Reset: assert rst 2 cycles mid-scan → bcd_out=16'hFFFF, blank_out=4'b1111, all flags 0; the partial frame is dropped.
- Clean scan of "2024": each digit held 8 cycles, dig_sel 0001→0010→0100→1000 with 2-0-2-4 patterns → a single frame_valid pulse, bcd_out=16'h4202 (nibble0=2), frame_err=0.
- Debounce: a digit held only 3 cycles (STABLE_CYCLES=4), then the full scan → the short dwell is not captured and no frame is committed until that digit dwells ≥4 cycles; no extra frame_valid.
- Illegal pattern: digit 1 = 1000000 in an otherwise legal scan → pattern_err pulses once; the frame commits with nibble1=4'hE and frame_err=1.
- Blank and non-one-hot: dig_sel=0011 for 10 cycles gives no capture; digit 3 dark gives blank_out[3]=1 and nibble3=4'hF with frame_err=0.
- Recapture: digit 0 shown as 5, then as 7, before the remaining digits → committed nibble0=7 with exactly one frame_valid.
